// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and frame constants for the FIFO-fed UART transmitter.
// Macro UART_TX_PARITY_EN adds the PARITY state and selects the 11-bit frame length.
package uart_pkg;
  localparam int DATA_BITS        = 8;
  localparam int BYTES_PER_WORD   = 2;
  localparam int FRAME_BITS_NOPAR = DATA_BITS + 2;
  localparam int FRAME_BITS_PAR   = DATA_BITS + 3;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam int WORD_BITS = FRAME_BITS * BYTES_PER_WORD;
endpackage

// File: rtl/baud_gen.sv
// baud_gen: bit-period timer; counts CLKS_PER_BIT cycles and restarts at every bit boundary.
// Ports: clk, rst (async, active high), i_restart (hold counter at zero), o_bit_done (last cycle of a bit).
module baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_bit_done
);
  logic [15:0] r_cnt;
  assign o_bit_done = r_cnt == 16'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (i_restart || o_bit_done) ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 16-bit words from a FIFO and sends them as two UART frames, low byte first.
// Ports: clk, rst (async, active high), en (pop enable), fifo_data/fifo_numel (FIFO head and count),
// fifo_read (registered pop strobe), txd (serial out, idle high), busy (word in flight).
// Macro UART_TX_PARITY_EN inserts an even-parity bit before each stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] fifo_data,
  input  logic [3:0]  fifo_numel,
  output logic        fifo_read,
  output logic        txd,
  output logic        busy
);
  state_t      r_state, w_next;
  logic [15:0] r_word;
  logic [2:0]  r_bit;
  logic        r_byte;
  logic        r_read;
  logic        w_bit_done;
  logic        w_take;
  logic        w_last;
  logic        w_restart;
  logic [7:0]  w_byte;
  assign w_take    = (r_state == IDLE) && en && (fifo_numel != 4'd0);
  assign w_last    = r_bit == 3'(DATA_BITS - 1);
  assign w_restart = r_state == IDLE;
  assign w_byte    = r_byte ? r_word[15:8] : r_word[7:0];
  assign fifo_read = r_read;
  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_bit_done(w_bit_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = w_take ? START : IDLE;
      START:  w_next = w_bit_done ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   w_next = (w_bit_done && w_last) ? PARITY : DATA;
      PARITY: w_next = w_bit_done ? STOP : PARITY;
`else
      DATA:   w_next = (w_bit_done && w_last) ? STOP : DATA;
`endif
      STOP:   w_next = w_bit_done ? (r_byte ? IDLE : START) : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    txd  = 1'b1;
    case (r_state)
      START:  txd = 1'b0;
      DATA:   txd = w_byte[r_bit];
`ifdef UART_TX_PARITY_EN
      PARITY: txd = ^w_byte;
`endif
      default: txd = 1'b1;
    endcase
  end
  // r_bit wraps 7->0 on its own, so it is already zero for the next byte; r_byte flips
  // after each stop bit and is back at zero when the word ends.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_word <= '0;
      r_bit  <= '0;
      r_byte <= 1'b0;
      r_read <= 1'b0;
    end else begin
      r_read <= w_take;
      if (w_take) begin
        r_word <= fifo_data;
        r_bit  <= '0;
        r_byte <= 1'b0;
      end
      if (r_state == DATA && w_bit_done) r_bit <= r_bit + 3'd1;
      if (r_state == STOP && w_bit_done) r_byte <= ~r_byte;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed scoreboard bench for fifo_uart_tx at CLKS_PER_BIT=4.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD = 2 * FB * CPB;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] fifo_data;
  logic [3:0]  fifo_numel;
  logic        fifo_read, txd, busy;
  logic [15:0] mem [16];
  int wp = 0, rp = 0, pops = 0, dbl = 0;
  logic prev_rd = 1'b0;
  int checks = 0, failures = 0;
  logic [15:0] exp_q [$];
  bit rst_seen = 0;
  always #5 clk = ~clk;
  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_data (fifo_data),
    .fifo_numel(fifo_numel),
    .fifo_read (fifo_read),
    .txd       (txd),
    .busy      (busy)
  );
  assign fifo_numel = 4'(wp - rp);
  assign fifo_data  = mem[rp[3:0]];
  always @(posedge clk) begin
    if (fifo_read) begin
      rp   <= rp + 1;
      pops <= pops + 1;
    end
    if (fifo_read && prev_rd) dbl <= dbl + 1;
    prev_rd <= fifo_read;
  end
  always @(posedge rst) rst_seen = 1;
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic push_raw(input logic [15:0] w);
    mem[wp[3:0]] = w;
    wp++;
  endtask
  task automatic push(input logic [15:0] w);
    push_raw(w);
    exp_q.push_back(w);
  endtask
  function automatic logic [21:0] frame(input logic [15:0] w);
    logic [21:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? w[7:0] : w[15:8];
      f[i*FB] = 1'b0;
      for (int j = 0; j < 8; j++) f[i*FB+1+j] = b[j];
`ifdef UART_TX_PARITY_EN
      f[i*FB+9] = ^b;
`endif
      f[i*FB+FB-1] = 1'b1;
    end
    return f;
  endfunction
  task automatic xmit(input logic [15:0] w, input bit b2b, input string nm);
    logic [99:0] cap, ex;
    logic [21:0] fb;
    int wt, n;
    fb = frame(w);
    ex = '0;
    for (int c = 0; c < WORD; c++) ex[c] = fb[c/CPB];
    wt = 0;
    while (!busy && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    cap = '0;
    n = 0;
    while (busy && n < 100) begin
      cap[n] = txd;
      n++;
      @(negedge clk);
    end
    chk({nm, "_len"}, n, WORD);
    chk({nm, "_txd"}, cap, ex);
    if (b2b) chk({nm, "_gap"}, wt, 1);
  endtask
  initial begin : monitor
    logic [10:0] fr;
    logic [7:0]  by0, by1;
    bit ok;
    forever begin
      ok = 1;
      by0 = '0;
      by1 = '0;
      for (int b = 0; b < 2 && ok; b++) begin
        do @(negedge clk); while (rst || txd !== 1'b0);
        if (b == 0) rst_seen = 0;
        fr = '1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < FB; k++) begin
          if (rst_seen) break;
          fr[k] = txd;
          if (k < FB - 1) repeat (CPB) @(negedge clk);
        end
        if (rst_seen) ok = 0;
        else begin
          chk("frame_start", fr[0], 1'b0);
          chk("frame_stop", fr[FB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
          chk("frame_parity", fr[9], ^fr[8:1]);
`endif
          if (b == 0) by0 = fr[8:1];
          else by1 = fr[8:1];
        end
      end
      if (ok) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected: got %h expected none", {by1, by0});
        end else chk("word", {by1, by0}, exp_q.pop_front());
      end
    end
  end
  initial begin : stim
    int p0, wt, txd_bad, busy_bad;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read", fifo_read, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    p0 = pops;
    txd_bad = 0;
    busy_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_bad++;
      if (txd !== 1'b1) txd_bad++;
    end
    chk("idle_pops", pops - p0, 0);
    chk("idle_busy", busy_bad, 0);
    chk("idle_txd", txd_bad, 0);
    p0 = pops;
    push(16'hA55A);
    xmit(16'hA55A, 0, "w_a55a");
    chk("w_a55a_pops", pops - p0, 1);
    p0 = pops;
    push(16'h0001);
    push(16'h8000);
    push(16'hFFFF);
    xmit(16'h0001, 0, "b2b_0001");
    xmit(16'h8000, 1, "b2b_8000");
    xmit(16'hFFFF, 1, "b2b_ffff");
    chk("b2b_pops", pops - p0, 3);
    p0 = pops;
    push(16'h1234);
    push_raw(16'h5678);
    fork
      xmit(16'h1234, 0, "en_drop");
      begin
        repeat (10) @(negedge clk);
        en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("en_drop_pops", pops - p0, 1);
    chk("en_drop_busy", busy, 1'b0);
    chk("en_drop_numel", fifo_numel, 4'd1);
    p0 = pops;
    en = 1'b1;
    wt = 0;
    while (!busy && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("abort_started", busy, 1'b1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_txd", txd, 1'b1);
    chk("abort_busy", busy, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_read", fifo_read, 1'b0);
    chk("abort_pops", pops - p0, 1);
    push(16'hC3E1);
    p0 = pops;
    rst = 1'b0;
    xmit(16'hC3E1, 0, "post_rst");
    chk("post_rst_pops", pops - p0, 1);
    p0 = pops;
    push(16'h0703);
    xmit(16'h0703, 0, "w_0703");
    chk("w_0703_pops", pops - p0, 1);
    repeat (10) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    chk("dbl_read", dbl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit, legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  level enable; new words are popped only while high.
REQ-005 fifo_data  input  16  head-of-FIFO word, valid combinationally whenever fifo_numel != 0.
REQ-006 fifo_numel  input  4  FIFO occupancy, 0..15.
REQ-007 fifo_read  output  1  registered pop strobe to the FIFO read port.
REQ-008 txd  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a word is being transmitted.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be reachable only when UART_TX_PARITY_EN is defined.
REQ-011 In IDLE, on a posedge where en=1 and fifo_numel!=0, the block SHALL capture fifo_data into a 16-bit holding register, set byte index to 0, go to START, and drive fifo_read=1 for exactly the following cycle.
REQ-012 fifo_read SHALL never be high for more than one consecutive cycle and SHALL never be asserted outside the IDLE->START transition.
REQ-013 Each bit (start, data, parity, stop) SHALL hold txd for exactly CLKS_PER_BIT cycles, timed by a counter restarted at every bit boundary.
REQ-014 Byte order: low byte (bits 7:0) first, then high byte (bits 15:8); bit order within each byte LSB first.
REQ-015 Frame per byte: start bit 0, 8 data bits, optional parity, stop bit 1.
REQ-016 After the low byte's stop bit, the FSM SHALL go directly to START for the high byte with no idle gap.
REQ-017 After the high byte's stop bit, the FSM SHALL return to IDLE; the earliest next capture is the first posedge in IDLE, so back-to-back words have zero extra idle bit time.
REQ-018 busy SHALL be high in every state except IDLE.
REQ-019 Deasserting en mid-word SHALL NOT abort; the current word completes, then the block stays in IDLE.
REQ-020 fifo_numel changes during transmission SHALL be ignored until IDLE.
REQ-021 Total word time SHALL be 20*CLKS_PER_BIT cycles without parity, 22*CLKS_PER_BIT with parity.

Reset
REQ-022 While rst is high: state=IDLE, txd=1, busy=0, fifo_read=0, all counters and the holding register 0, independent of clk.
REQ-023 Reset asserted mid-word SHALL abort immediately (txd to 1 asynchronously); the popped word is lost, no re-pop.
REQ-024 After rst deasserts, the first capture SHALL occur no earlier than the first posedge with rst low.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent between the last data bit and the stop bit of each byte; when undefined, no parity state or logic SHALL exist.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum type, DATA_BITS=8, BYTES_PER_WORD=2, and the frame-length constants for both parity settings.
REQ-027 One sub-module, baud_gen (counter with restart input and bit_done output, parameterised by CLKS_PER_BIT), SHALL provide bit timing.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset then idle with fifo_numel=0, en=1 -> txd=1, busy=0, fifo_read never asserted for 100 cycles.
REQ-029 One word 16'hA55A, numel 1->0 after pop -> exactly one fifo_read pulse; txd = 0,0,1,0,1,1,0,1,0,1, then 0,1,0,1,0,0,1,0,1,1 (4 cycles each); busy high for 80 cycles.
REQ-030 Three words queued (16'h0001, 16'h8000, 16'hFFFF) -> three pops, 240 cycles of continuous frames with no idle bit between words.
REQ-031 en dropped 10 cycles into word 16'h1234 with numel=2 -> word completes in full, no second pop, busy falls at cycle 80.
REQ-032 rst asserted 30 cycles into a word -> txd=1 and busy=0 the same cycle; after release with numel=1, next word starts cleanly with a single pop.
REQ-033 With UART_TX_PARITY_EN defined, word 16'h0703 -> parity bits 0 (low byte 8'h03) and 1 (high byte 8'h07); word time 88 cycles.
